spi_engine_cmd_gen: RTL and testbench

SPI_ENGINE_CMD_GEN -- requirements
Module: spi_engine_cmd_gen

---
 rtl/spi_engine_instr_pkg.sv | 32 +++
 rtl/spi_engine_xfer_split.sv | 18 +
 rtl/spi_engine_cmd_gen.sv | 203 ++++++++++++++++++++
 tb/tb_spi_engine_cmd_gen.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/spi_engine_instr_pkg.sv
// Opcodes, FSM state encoding and transfer chunk size shared by the SPI engine command generator.
// SPI_ENGINE_CMD_GEN_SLEEP_EN adds the optional SLEEP state.
package spi_engine_instr_pkg;

  localparam int CHUNK_WORDS = 256;

  localparam logic [15:0] OP_CFG   = 16'h2100;
  localparam logic [15:0] OP_PRESC = 16'h2000;
  localparam logic [15:0] OP_DLEN  = 16'h2200;
  localparam logic [15:0] OP_CS    = 16'h1000;
  localparam logic [15:0] OP_SLEEP = 16'h3100;
  localparam logic [15:0] OP_SYNC  = 16'h3000;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CFG,
    ST_PRESC,
    ST_DLEN,
    ST_CS_ON,
`ifdef SPI_ENGINE_CMD_GEN_SLEEP_EN
    ST_SLEEP,
`endif
    ST_XFER,
    ST_CS_OFF,
    ST_SYNC
  } state_t;

  function automatic logic [15:0] enc_cs(input logic [1:0] delay, input logic [7:0] mask);
    return OP_CS | {6'b0, delay, mask};
  endfunction

endpackage

// File: rtl/spi_engine_xfer_split.sv
// Splits a remaining word count into 256-word chunks: (n-1) of the next chunk and a last-chunk flag.
module spi_engine_xfer_split
  import spi_engine_instr_pkg::*;
#(
  parameter int WORDS_W = 12
) (
  input  logic [WORDS_W-1:0] remaining,
  output logic [7:0]         chunk_m1,
  output logic               last
);

  logic [WORDS_W-1:0] rem_m1;

  assign last     = (32'(remaining) <= CHUNK_WORDS);
  assign rem_m1   = remaining - WORDS_W'(1);
  assign chunk_m1 = last ? 8'(rem_m1) : 8'(CHUNK_WORDS - 1);

endmodule

// File: rtl/spi_engine_cmd_gen.sv
// Turns one SPI request into a stream of SPI engine instructions, skipping config already applied.
// Optional SLEEP instruction after chip-select is enabled by SPI_ENGINE_CMD_GEN_SLEEP_EN.
//
// state     | meaning
// IDLE      | waiting for a request, req_ready high
// CFG       | presenting CFG (mode bits), skipped on cache hit
// PRESC     | presenting PRESCALE, skipped on cache hit
// DLEN      | presenting DLENGTH, skipped on cache hit
// CS_ON     | asserting the selected chip select
// SLEEP     | optional delay after chip-select
// XFER      | one WR/RD/WRD instruction per 256-word chunk
// CS_OFF    | releasing all chip selects
// SYNC      | sync marker; handshake pulses done
module spi_engine_cmd_gen
  import spi_engine_instr_pkg::*;
#(
  parameter int NUM_CS  = 1,
  parameter int WORDS_W = 12,
  parameter int INST_W  = 32
) (
  input  logic                                     clk,
  input  logic                                     resetn,
  input  logic                                     req_valid,
  output logic                                     req_ready,
  input  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] req_cs,
  input  logic [1:0]                               req_mode,
  input  logic [WORDS_W-1:0]                       req_words,
  input  logic                                     req_cpol,
  input  logic                                     req_cpha,
  input  logic                                     req_3wire,
  input  logic [7:0]                               req_div,
  input  logic [7:0]                               req_dlen,
  input  logic [1:0]                               req_cs_delay,
  input  logic [7:0]                               req_sleep,
  input  logic [7:0]                               req_id,
  output logic                                     cmd_valid,
  input  logic                                     cmd_ready,
  output logic [INST_W-1:0]                        cmd_data,
  output logic                                     busy,
  output logic                                     done
);

  localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  state_t             state, nxt;
  logic [CS_W-1:0]    l_cs, f_cs;
  logic [1:0]         l_mode, f_mode, l_delay, f_delay;
  logic [2:0]         l_cfg, f_cfg, c_cfg;
  logic [7:0]         l_div, f_div, c_div, l_dlen, f_dlen, c_dlen, l_id, f_id;
  logic [WORDS_W-1:0] remaining, f_words, split_in;
  logic               cfg_ok, div_ok, dlen_ok, xfer_last;
  logic               need_cfg, need_div, need_dlen, has_xfer, has_sleep, idle;
  logic [7:0]         cs_mask, split_m1;
  logic               split_last;
  logic [15:0]        nxt_data;

`ifdef SPI_ENGINE_CMD_GEN_SLEEP_EN
  logic [7:0] l_sleep, f_sleep;
  assign f_sleep   = idle ? req_sleep : l_sleep;
  assign has_sleep = (f_sleep != 8'h00);
`else
  logic unused_sleep;
  assign unused_sleep = ^req_sleep;
  assign has_sleep    = 1'b0;
`endif

  // While idle the successor is computed from the live request so the first
  // instruction can be registered on the request handshake itself.
  assign idle    = (state == ST_IDLE);
  assign f_cs    = idle ? req_cs : l_cs;
  assign f_mode  = idle ? req_mode : l_mode;
  assign f_delay = idle ? req_cs_delay : l_delay;
  assign f_cfg   = idle ? {req_3wire, req_cpol, req_cpha} : l_cfg;
  assign f_div   = idle ? req_div : l_div;
  assign f_dlen  = idle ? req_dlen : l_dlen;
  assign f_id    = idle ? req_id : l_id;
  assign f_words = idle ? req_words : remaining;

  assign need_cfg  = !cfg_ok || (c_cfg != f_cfg);
  assign need_div  = !div_ok || (c_div != f_div);
  assign need_dlen = !dlen_ok || (c_dlen != f_dlen);
  assign has_xfer  = (f_mode != 2'b00) && (f_words != '0);

  assign split_in = (state == ST_XFER) ? remaining - WORDS_W'(CHUNK_WORDS) : f_words;

  spi_engine_xfer_split #(.WORDS_W(WORDS_W)) u_split (
    .remaining (split_in),
    .chunk_m1  (split_m1),
    .last      (split_last)
  );

  always_comb begin
    cs_mask = 8'hFF;
    if (32'(f_cs) < NUM_CS) cs_mask[3'(f_cs)] = 1'b0;
  end

  always_comb begin
    nxt = ST_IDLE;
    case (state)
      ST_IDLE:   nxt = need_cfg ? ST_CFG : need_div ? ST_PRESC : need_dlen ? ST_DLEN : ST_CS_ON;
      ST_CFG:    nxt = need_div ? ST_PRESC : need_dlen ? ST_DLEN : ST_CS_ON;
      ST_PRESC:  nxt = need_dlen ? ST_DLEN : ST_CS_ON;
      ST_DLEN:   nxt = ST_CS_ON;
`ifdef SPI_ENGINE_CMD_GEN_SLEEP_EN
      ST_CS_ON:  nxt = has_sleep ? ST_SLEEP : has_xfer ? ST_XFER : ST_CS_OFF;
      ST_SLEEP:  nxt = has_xfer ? ST_XFER : ST_CS_OFF;
`else
      ST_CS_ON:  nxt = (has_xfer && !has_sleep) ? ST_XFER : ST_CS_OFF;
`endif
      ST_XFER:   nxt = xfer_last ? ST_CS_OFF : ST_XFER;
      ST_CS_OFF: nxt = ST_SYNC;
      ST_SYNC:   nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    nxt_data = 16'h0000;
    case (nxt)
      ST_CFG:    nxt_data = OP_CFG | {13'b0, f_cfg};
      ST_PRESC:  nxt_data = OP_PRESC | {8'b0, f_div};
      ST_DLEN:   nxt_data = OP_DLEN | {8'b0, f_dlen};
      ST_CS_ON:  nxt_data = enc_cs(f_delay, cs_mask);
`ifdef SPI_ENGINE_CMD_GEN_SLEEP_EN
      ST_SLEEP:  nxt_data = OP_SLEEP | {8'b0, f_sleep};
`endif
      ST_XFER:   nxt_data = {6'b0, f_mode, split_m1};
      ST_CS_OFF: nxt_data = enc_cs(f_delay, 8'hFF);
      ST_SYNC:   nxt_data = OP_SYNC | {8'b0, f_id};
      default:   nxt_data = 16'h0000;
    endcase
  end

  assign done = (state == ST_SYNC) && cmd_valid && cmd_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      req_ready <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_data  <= '0;
      busy      <= 1'b0;
      l_cs      <= '0;
      l_mode    <= 2'b00;
      l_delay   <= 2'b00;
      l_cfg     <= 3'b000;
      l_div     <= 8'h00;
      l_dlen    <= 8'h00;
      l_id      <= 8'h00;
`ifdef SPI_ENGINE_CMD_GEN_SLEEP_EN
      l_sleep   <= 8'h00;
`endif
      remaining <= '0;
      xfer_last <= 1'b0;
      c_cfg     <= 3'b000;
      c_div     <= 8'h00;
      c_dlen    <= 8'h00;
      cfg_ok    <= 1'b0;
      div_ok    <= 1'b0;
      dlen_ok   <= 1'b0;
    end else if (idle) begin
      if (req_valid && req_ready) begin
        l_cs      <= req_cs;
        l_mode    <= req_mode;
        l_delay   <= req_cs_delay;
        l_cfg     <= {req_3wire, req_cpol, req_cpha};
        l_div     <= req_div;
        l_dlen    <= req_dlen;
        l_id      <= req_id;
`ifdef SPI_ENGINE_CMD_GEN_SLEEP_EN
        l_sleep   <= req_sleep;
`endif
        remaining <= req_words;
        state     <= nxt;
        cmd_valid <= 1'b1;
        cmd_data  <= INST_W'(nxt_data);
        busy      <= 1'b1;
        req_ready <= 1'b0;
      end else begin
        req_ready <= 1'b1;
      end
    end else if (cmd_valid && cmd_ready) begin
      state <= nxt;
      case (state)
        ST_CFG:   begin c_cfg  <= l_cfg;  cfg_ok  <= 1'b1; end
        ST_PRESC: begin c_div  <= l_div;  div_ok  <= 1'b1; end
        ST_DLEN:  begin c_dlen <= l_dlen; dlen_ok <= 1'b1; end
        default:  ;
      endcase
      if (state == ST_XFER && !xfer_last) remaining <= split_in;
      if (nxt == ST_XFER) xfer_last <= split_last;
      if (nxt == ST_IDLE) begin
        cmd_valid <= 1'b0;
        cmd_data  <= '0;
        busy      <= 1'b0;
        req_ready <= 1'b1;
      end else begin
        cmd_data <= INST_W'(nxt_data);
      end
    end
  end

endmodule

// File: tb/tb_spi_engine_cmd_gen.sv
// Directed bench for spi_engine_cmd_gen (NUM_CS=3 so an out-of-range chip select is reachable).
// Expectations include the SLEEP instruction only when SPI_ENGINE_CMD_GEN_SLEEP_EN is defined.
module tb_spi_engine_cmd_gen;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid, req_ready;
  logic [1:0]  req_cs, req_mode, req_cs_delay;
  logic [11:0] req_words;
  logic        req_cpol, req_cpha, req_3wire;
  logic [7:0]  req_div, req_dlen, req_sleep, req_id;
  logic        cmd_valid, cmd_ready, busy, done;
  logic [31:0] cmd_data;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  spi_engine_cmd_gen #(.NUM_CS(3), .WORDS_W(12), .INST_W(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_cs       (req_cs),
    .req_mode     (req_mode),
    .req_words    (req_words),
    .req_cpol     (req_cpol),
    .req_cpha     (req_cpha),
    .req_3wire    (req_3wire),
    .req_div      (req_div),
    .req_dlen     (req_dlen),
    .req_cs_delay (req_cs_delay),
    .req_sleep    (req_sleep),
    .req_id       (req_id),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_data     (cmd_data),
    .busy         (busy),
    .done         (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic send_req(input string tag, input logic [1:0] cs, input logic [1:0] mode,
                          input logic [11:0] words, input logic cpol, input logic cpha,
                          input logic w3, input logic [7:0] div, input logic [7:0] dlen,
                          input logic [1:0] dly, input logic [7:0] slp, input logic [7:0] id);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    req_cs = cs; req_mode = mode; req_words = words; req_cpol = cpol; req_cpha = cpha;
    req_3wire = w3; req_div = div; req_dlen = dlen; req_cs_delay = dly; req_sleep = slp;
    req_id = id; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({tag, "_first_valid"}, {31'b0, cmd_valid}, 32'd1);
    check({tag, "_busy"}, {31'b0, busy}, 32'd1);
  endtask

  task automatic collect(input string tag, input bit rnd, input int exp_done_cyc);
    int          i = 0;
    int          cyc = 0;
    int          done_cyc = -1;
    bit          stalled = 1'b0;
    logic [31:0] held = '0;
    while (i < exp_q.size() && cyc < 3000) begin
      cyc++;
      if (stalled) begin
        check({tag, "_hold_valid"}, {31'b0, cmd_valid}, 32'd1);
        check({tag, "_hold_data"}, cmd_data, held);
      end
      cmd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      stalled = cmd_valid && !cmd_ready;
      held    = cmd_data;
      if (cmd_valid && cmd_ready) begin
        check($sformatf("%s_instr%0d", tag, i), cmd_data, exp_q[i]);
        check($sformatf("%s_done%0d", tag, i), {31'b0, done},
              (i == exp_q.size() - 1) ? 32'd1 : 32'd0);
        if (done) done_cyc = cyc;
        i++;
      end
      @(posedge clk); #1;
    end
    cmd_ready = 1'b1;
    check({tag, "_count"}, 32'(i), 32'(exp_q.size()));
    if (exp_done_cyc > 0) check({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done_cyc));
    check({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_idle_valid"}, {31'b0, cmd_valid}, 32'd0);
    check({tag, "_idle_ready"}, {31'b0, req_ready}, 32'd1);
  endtask

  task automatic check_in_reset(input string tag);
    check({tag, "_rst_valid"}, {31'b0, cmd_valid}, 32'd0);
    check({tag, "_rst_data"}, cmd_data, 32'd0);
    check({tag, "_rst_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_rst_done"}, {31'b0, done}, 32'd0);
    check({tag, "_rst_ready"}, {31'b0, req_ready}, 32'd0);
  endtask

  task automatic release_reset(input string tag);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    check({tag, "_ready_after_rst"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    int n;
    resetn = 1'b0; req_valid = 1'b0; cmd_ready = 1'b1;
    req_cs = '0; req_mode = '0; req_words = '0; req_cpol = 1'b0; req_cpha = 1'b0;
    req_3wire = 1'b0; req_div = '0; req_dlen = '0; req_cs_delay = '0; req_sleep = '0;
    req_id = '0;
    repeat (3) @(posedge clk);
    #1;
    check_in_reset("por");
    release_reset("por");

    // Cold request: full config emitted, SYNC handshake in cycle 7
    send_req("cold", 2'd0, 2'b01, 12'd4, 1'b0, 1'b1, 1'b0, 8'd3, 8'd8, 2'd0, 8'd0, 8'd5);
    exp_q = '{32'h2101, 32'h2003, 32'h2208, 32'h10FE, 32'h0103, 32'h10FF, 32'h3005};
    collect("cold", 1'b0, 7);

    send_req("warm", 2'd0, 2'b01, 12'd4, 1'b0, 1'b1, 1'b0, 8'd3, 8'd8, 2'd0, 8'd0, 8'd5);
    exp_q = '{32'h10FE, 32'h0103, 32'h10FF, 32'h3005};
    collect("warm", 1'b0, 4);

    // 600 words = 256 + 256 + 88
    send_req("split", 2'd2, 2'b11, 12'd600, 1'b0, 1'b1, 1'b0, 8'd3, 8'd8, 2'd0, 8'd0, 8'd9);
    exp_q = '{32'h10FB, 32'h03FF, 32'h03FF, 32'h0357, 32'h10FF, 32'h3009};
    collect("split", 1'b0, 6);

    // cs beyond NUM_CS, no transfer, partial config change (div unchanged)
    send_req("nocs", 2'd3, 2'b00, 12'd5, 1'b1, 1'b0, 1'b1, 8'd3, 8'd16, 2'd2, 8'd0, 8'hA5);
    exp_q = '{32'h2106, 32'h2210, 32'h12FF, 32'h12FF, 32'h30A5};
    collect("nocs", 1'b0, 5);

    send_req("w257", 2'd1, 2'b10, 12'd257, 1'b1, 1'b0, 1'b1, 8'd3, 8'd16, 2'd1, 8'd0, 8'h11);
    exp_q = '{32'h11FD, 32'h02FF, 32'h0200, 32'h11FF, 32'h3011};
    collect("w257", 1'b0, 5);

    send_req("w0", 2'd0, 2'b11, 12'd0, 1'b1, 1'b0, 1'b1, 8'd3, 8'd16, 2'd3, 8'd0, 8'h22);
    exp_q = '{32'h13FE, 32'h13FF, 32'h3022};
    collect("w0", 1'b0, 3);

    // Reset while an XFER instruction is pending
    send_req("midrst", 2'd0, 2'b01, 12'd600, 1'b1, 1'b0, 1'b1, 8'd3, 8'd16, 2'd0, 8'd0, 8'h01);
    cmd_ready = 1'b1;
    n = 0;
    while (!(cmd_valid && cmd_data[15:8] == 8'h01) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("midrst_reached_xfer", {31'b0, cmd_valid}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    check_in_reset("midrst");
    release_reset("midrst");

    send_req("postrst", 2'd0, 2'b01, 12'd4, 1'b0, 1'b1, 1'b0, 8'd3, 8'd8, 2'd0, 8'd16, 8'd5);
    exp_q = '{32'h2101, 32'h2003, 32'h2208, 32'h10FE};
`ifdef SPI_ENGINE_CMD_GEN_SLEEP_EN
    exp_q.push_back(32'h3110);
`endif
    exp_q.push_back(32'h0103);
    exp_q.push_back(32'h10FF);
    exp_q.push_back(32'h3005);
    collect("postrst", 1'b0, 0);

    // Random backpressure on a cold cache
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk); #1;
    release_reset("stall");
    send_req("stall", 2'd0, 2'b01, 12'd4, 1'b0, 1'b1, 1'b0, 8'd3, 8'd8, 2'd0, 8'd0, 8'd5);
    exp_q = '{32'h2101, 32'h2003, 32'h2208, 32'h10FE, 32'h0103, 32'h10FF, 32'h3005};
    collect("stall", 1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
